// File: rtl/voice_ev_if.sv
// Note event channel: valid/ready handshake carrying a note-on/off flag and note number.
interface voice_ev_if #(
  parameter int unsigned NOTE_W = 7
);
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphony controller: maps note events onto ADSR voices, steals the oldest voice when
// full, and holds a retriggered gate low long enough for the ADSR edge detector.
module voice_allocator #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned NOTE_W      = 7,
  parameter int unsigned AGE_W       = 8,
  parameter int unsigned KILL_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  voice_ev_if.slave                    ev,
  input  logic [NUM_VOICES-1:0]        voice_idle,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         steal_pulse,
  output logic                         busy
);

  localparam int unsigned TGT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned KC_W  = $clog2(KILL_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_KILL, ST_ASSIGN, ST_GATE
  } state_e;

  state_e              state_q, state_d;
  logic                ev_on_q, ev_on_d;
  logic [NOTE_W-1:0]   ev_note_q, ev_note_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [KC_W-1:0]     kcnt_q, kcnt_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NOTE_W-1:0]   note_q [NUM_VOICES];
  logic [NOTE_W-1:0]   note_d [NUM_VOICES];
  logic [AGE_W-1:0]    age_q  [NUM_VOICES];
  logic [AGE_W-1:0]    age_d  [NUM_VOICES];
  logic                steal_q, steal_d;

  logic             same_hit, idle_hit, rel_hit, gated_hit;
  logic [TGT_W-1:0] same_idx, idle_idx, rel_idx, gated_idx;
  logic [AGE_W-1:0] rel_age, gated_age;

  assign ev.ev_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign voice_gate   = gate_q;
  assign steal_pulse  = steal_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_flat
    assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
  end

  // Candidate search for each priority class; lowest index wins ties, oldest wins by age.
  always_comb begin
    same_hit  = 1'b0; same_idx  = '0;
    idle_hit  = 1'b0; idle_idx  = '0;
    rel_hit   = 1'b0; rel_idx   = '0; rel_age   = '0;
    gated_hit = 1'b0; gated_idx = '0; gated_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_q[i] && (note_q[i] == ev_note_q) && !same_hit) begin
        same_hit = 1'b1;
        same_idx = TGT_W'(i);
      end
      if (!gate_q[i] && voice_idle[i] && !idle_hit) begin
        idle_hit = 1'b1;
        idle_idx = TGT_W'(i);
      end
      if (!gate_q[i] && !voice_idle[i] && (!rel_hit || (age_q[i] > rel_age))) begin
        rel_hit = 1'b1;
        rel_idx = TGT_W'(i);
        rel_age = age_q[i];
      end
      if (gate_q[i] && (!gated_hit || (age_q[i] > gated_age))) begin
        gated_hit = 1'b1;
        gated_idx = TGT_W'(i);
        gated_age = age_q[i];
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    tgt_d     = tgt_q;
    kcnt_d    = kcnt_q;
    gate_d    = gate_q;
    note_d    = note_q;
    age_d     = age_q;
    steal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev.ev_valid) begin
          ev_on_d   = ev.ev_on;
          ev_note_d = ev.ev_note;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        kcnt_d = '0;
        if (!ev_on_q) begin
          if (same_hit) gate_d[same_idx] = 1'b0;
          state_d = ST_IDLE;
        end else if (same_hit) begin
          tgt_d   = same_idx;
          state_d = ST_KILL;
        end else if (idle_hit) begin
          tgt_d   = idle_idx;
          state_d = ST_ASSIGN;
        end else if (rel_hit) begin
          tgt_d   = rel_idx;
          state_d = ST_ASSIGN;
        end else begin
          tgt_d   = gated_idx;
          steal_d = 1'b1;
          state_d = ST_KILL;
        end
      end
      ST_KILL: begin
        gate_d[tgt_q] = 1'b0;
        if (kcnt_q == KC_W'(KILL_CYCLES - 1)) begin
          state_d = ST_ASSIGN;
        end else begin
          kcnt_d = kcnt_q + KC_W'(1);
        end
      end
      ST_ASSIGN: begin
        note_d[tgt_q] = ev_note_q;
        state_d       = ST_GATE;
      end
      ST_GATE: begin
        gate_d[tgt_q] = 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (TGT_W'(i) == tgt_q) begin
            age_d[i] = '0;
          end else if (age_q[i] != AGE_MAX) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      tgt_q     <= '0;
      kcnt_q    <= '0;
      gate_q    <= '0;
      steal_q   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      tgt_q     <= tgt_d;
      kcnt_q    <= kcnt_d;
      gate_q    <= gate_d;
      steal_q   <= steal_d;
      note_q    <= note_d;
      age_q     <= age_d;
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller placed in front of an array of NUM_VOICES ADSR envelope voices.
- Accepts note-on and note-off events through a valid/ready handshake and assigns each note to a voice.
- Drives each voice's gate (ADSR note_on) and note number (ADSR voice_freq).
- Steals voices when none is free, and guarantees the gate low time the ADSR edge detector needs to retrigger.

Parameters:
- NUM_VOICES, 4, number of ADSR voices managed (2..8).
- NOTE_W, 7, note number width.
- AGE_W, 8, per-voice age counter width; counter saturates at its maximum.
- KILL_CYCLES, 2, cycles a gated voice is forced low before retrigger; minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ev_valid  in  1  event present
- ev_ready  out  1  event accepted when ev_valid && ev_ready
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note number
- voice_idle  in  NUM_VOICES  per voice, 1 = envelope in OFF (Level==0)
- voice_gate  out  NUM_VOICES  per-voice gate to ADSR note_on
- voice_note  out  NUM_VOICES*NOTE_W  per-voice note; voice i occupies bits [i*NOTE_W +: NOTE_W]
- steal_pulse  out  1  one-cycle pulse when a sounding voice is stolen
- busy  out  1  state != IDLE

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE, voice_gate 0, voice_note 0, all ages 0, steal_pulse 0, ev_ready 1, busy 0.
- Reset mid-operation clears everything immediately; any pending event is dropped.
- ev_ready = (state==IDLE), combinational. ev_on and ev_note are latched on acceptance.
- FSM states: IDLE, SCAN, KILL, ASSIGN, GATE.
- IDLE -> SCAN on acceptance.
- SCAN, note-off:
  - Target is the lowest-index voice with gate=1 and note==ev_note.
  - If found, clear its gate at this edge.
  - Go to IDLE in either case; an unmatched note-off is silently ignored.
- SCAN, note-on: choose the target by priority; ties go to the lowest index.
  - (a) A gated voice with the same note. This is a retrigger: go to KILL, no steal_pulse.
  - (b) A voice with gate=0 and voice_idle=1: go to ASSIGN.
  - (c) A voice with gate=0 and voice_idle=0 (releasing), highest age: go to ASSIGN.
  - (d) A gated voice with highest age: this is a steal. steal_pulse=1 for exactly this cycle; go to KILL.
  - voice_idle is sampled only in SCAN.
- KILL:
  - Target gate is forced 0.
  - The KILL counter counts KILL_CYCLES cycles, then the FSM goes to ASSIGN.
  - Target gate stays low through KILL and ASSIGN, giving KILL_CYCLES+1 low cycles. This is ≥ 3 cycles, satisfying the ADSR two-stage edge detector.
- ASSIGN: voice_note[target] <= ev_note; go to GATE. Note is therefore stable at least one cycle before the gate rises.
- GATE:
  - voice_gate[target] <= 1.
  - age[target] <= 0.
  - Every other voice's age increments, saturating at 2^AGE_W-1.
  - Go to IDLE.
- Latency, counted from the acceptance edge E0:
  - Free-voice note-on: gate high after edge E3. Next event can be accepted at E4.
  - Retrigger or steal: gate high after edge E3+KILL_CYCLES.
  - Note-off: gate low after edge E1.
- Ages change only in GATE. Note-off does not modify ages.
- voice_note holds its value after the gate falls, so the release tail keeps its pitch.
- ev_valid is ignored outside IDLE. The event source holds ev_valid and ev_note until acceptance.

Test Plan:
- After reset, note-on 60 with voice_idle=1111 → ev_ready low 3 cycles; voice_gate=0001 after E3; voice_note[0]=60; ev_ready high at E4.
- Note-ons 60,62,64,65, then 67 → voice 0 (age 3) is stolen: steal_pulse high 1 cycle; gate0 low 3 cycles; voice_note[0]=67; gate0 high; gates=1111.
- From 4 voices gated, note-off 62 → gate1 low after E1, others unchanged. Note-off 70 → no gate change, ev_ready back high after 1 cycle.
- Note-on 64 while voice 2 is gated on 64 → gate2 low for 3 cycles then high; voice_note[2]=64; steal_pulse stays 0; no other voice disturbed.
- All gates 0, voice_idle=0100 → next note-on goes to voice 2. voice_idle=0000 with ages {5,9,2,7} → voice 1 is chosen.
- Assert rst during KILL → voice_gate=0, voice_note=0, steal_pulse=0, ev_ready=1 immediately (asynchronous); after release, a note-on 48 lands in voice 0.
